// File: rtl/axi4l_pkg.sv
// axi4l_pkg
//   Shared AXI4-Lite types for the SoC fabric: address/data/strobe/response
//   widths, response codes, and the state enum used by the Ibex data-port
//   bridge (ibex_data_axi4l_master).
package axi4l_pkg;

  typedef logic [31:0] addr_t;
  typedef logic [31:0] data_t;
  typedef logic [3:0]  strb_t;
  typedef logic [1:0]  resp_t;

  localparam resp_t OKAY   = 2'b00;
  localparam resp_t EXOKAY = 2'b01;
  localparam resp_t SLVERR = 2'b10;
  localparam resp_t DECERR = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    WB,
    RA,
    RD
  } axi4l_mst_state_t;

  // SLVERR and DECERR both have bit 1 set; OKAY and EXOKAY do not.
  function automatic logic resp_is_err(resp_t r);
    return r[1];
  endfunction

endpackage

// File: rtl/axi4l_if.sv
// axi4l_if
//   AXI4-Lite bundle with master and slave modports.
//   aclk/aresetn : fabric clock and active-low reset
//   AW/W/B/AR/R  : the five AXI4-Lite channels
interface axi4l_if
  import axi4l_pkg::*;
(
  input logic aclk,
  input logic aresetn
);

  addr_t      awaddr;
  logic [2:0] awprot;
  logic       awvalid;
  logic       awready;

  data_t      wdata;
  strb_t      wstrb;
  logic       wvalid;
  logic       wready;

  resp_t      bresp;
  logic       bvalid;
  logic       bready;

  addr_t      araddr;
  logic [2:0] arprot;
  logic       arvalid;
  logic       arready;

  data_t      rdata;
  resp_t      rresp;
  logic       rvalid;
  logic       rready;

  modport master (
    input  aclk, aresetn,
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid,    input wready,
    input  bresp, bvalid,           output bready,
    output araddr, arprot, arvalid, input arready,
    input  rdata, rresp, rvalid,    output rready
  );

  modport slave (
    input  aclk, aresetn,
    input  awaddr, awprot, awvalid, output awready,
    input  wdata, wstrb, wvalid,    output wready,
    output bresp, bvalid,           input bready,
    input  araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid,    input rready
  );

endinterface

// File: rtl/ibex_data_axi4l_master.sv
// ibex_data_axi4l_master
//   Bridges the Ibex data-memory req/gnt/rvalid port onto one AXI4-Lite
//   master port. One transaction outstanding; the response comes back as a
//   single-cycle data_rvalid_o pulse.
//
//   aclk          : clock (same as axi.aclk)
//   areset        : synchronous active-high reset (axi.aresetn is ignored)
//   data_req_i    : core request
//   data_gnt_o    : request accepted this cycle (combinational)
//   data_we_i     : 1 = write, 0 = read
//   data_be_i     : byte enables
//   data_addr_i   : byte address
//   data_wdata_i  : write data
//   data_rvalid_o : one-cycle response pulse
//   data_rdata_o  : read data, valid with data_rvalid_o (0 for writes)
//   data_err_o    : bus error, valid with data_rvalid_o
//   axi           : AXI4-Lite master port
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | waiting for a core request; grant is given only here
//   WR    | AW and W presented, each dropped once its handshake is done
//   WB    | both write handshakes done, waiting for B
//   RA    | AR presented
//   RD    | waiting for R
module ibex_data_axi4l_master
  import axi4l_pkg::*;
(
  input  logic         aclk,
  input  logic         areset,
  input  logic         data_req_i,
  output logic         data_gnt_o,
  input  logic         data_we_i,
  input  logic [3:0]   data_be_i,
  input  logic [31:0]  data_addr_i,
  input  logic [31:0]  data_wdata_i,
  output logic         data_rvalid_o,
  output logic [31:0]  data_rdata_o,
  output logic         data_err_o,
  axi4l_if.master      axi
);

  axi4l_mst_state_t state_q, state_d;

  addr_t addr_q;
  data_t wdata_q;
  strb_t be_q;

  logic  aw_done_q, aw_done_d;
  logic  w_done_q,  w_done_d;
  logic  rvalid_q,  rvalid_d;
  logic  err_q,     err_d;
  data_t rdata_q,   rdata_d;

  logic  gnt;
  logic  aw_hs;
  logic  w_hs;

  // Gated by areset so a request seen during reset is never granted and lost.
  assign gnt = data_req_i && (state_q == IDLE) && !areset;

  always_comb begin
    state_d     = state_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    rvalid_d    = 1'b0;
    rdata_d     = rdata_q;
    err_d       = err_q;
    aw_hs       = 1'b0;
    w_hs        = 1'b0;
    axi.awvalid = 1'b0;
    axi.wvalid  = 1'b0;
    axi.bready  = 1'b0;
    axi.arvalid = 1'b0;
    axi.rready  = 1'b0;

    case (state_q)
      IDLE: begin
        if (gnt) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = data_we_i ? WR : RA;
        end
      end

      WR: begin
        axi.awvalid = !aw_done_q;
        axi.wvalid  = !w_done_q;
        aw_hs       = !aw_done_q && axi.awready;
        w_hs        = !w_done_q && axi.wready;
        aw_done_d   = aw_done_q || aw_hs;
        w_done_d    = w_done_q || w_hs;
        if (aw_done_d && w_done_d) begin
          state_d = WB;
        end
      end

      WB: begin
        axi.bready = 1'b1;
        if (axi.bvalid) begin
          rvalid_d = 1'b1;
          err_d    = resp_is_err(axi.bresp);
          rdata_d  = '0;
          state_d  = IDLE;
        end
      end

      RA: begin
        axi.arvalid = 1'b1;
        if (axi.arready) begin
          state_d = RD;
        end
      end

      RD: begin
        axi.rready = 1'b1;
        if (axi.rvalid) begin
          rvalid_d = 1'b1;
          err_d    = resp_is_err(axi.rresp);
          rdata_d  = axi.rdata;
          state_d  = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q   <= IDLE;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
    end
  end

  // Payload is only meaningful once a grant has loaded it, so it needs no reset.
  always_ff @(posedge aclk) begin
    if (gnt) begin
      addr_q  <= data_addr_i;
      wdata_q <= data_wdata_i;
      be_q    <= data_be_i;
    end
  end

  assign axi.awaddr = addr_q;
  assign axi.awprot = 3'b000;
  assign axi.wdata  = wdata_q;
  assign axi.wstrb  = be_q;
  assign axi.araddr = addr_q;
  assign axi.arprot = 3'b000;

  assign data_gnt_o    = gnt;
  assign data_rvalid_o = rvalid_q;
  assign data_rdata_o  = rdata_q;
  assign data_err_o    = err_q;

endmodule

// File: tb/tb_ibex_data_axi4l_master.sv
module tb_ibex_data_axi4l_master;
  import axi4l_pkg::*;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          aw_stall;
    int          w_stall;
    int          b_delay;
    int          ar_stall;
    int          r_delay;
    logic [1:0]  resp;
    logic        exp_err;
    logic [31:0] exp_rdata;
    int          exp_lat;
    logic [31:0] exp_word;
  } txn_t;

  logic        aclk = 1'b0;
  logic        areset;
  logic        data_req_i;
  logic        data_gnt_o;
  logic        data_we_i;
  logic [3:0]  data_be_i;
  logic [31:0] data_addr_i;
  logic [31:0] data_wdata_i;
  logic        data_rvalid_o;
  logic [31:0] data_rdata_o;
  logic        data_err_o;

  always #5 aclk = ~aclk;

  axi4l_if axi_bus (.aclk(aclk), .aresetn(!areset));

  ibex_data_axi4l_master dut (
    .aclk          (aclk),
    .areset        (areset),
    .data_req_i    (data_req_i),
    .data_gnt_o    (data_gnt_o),
    .data_we_i     (data_we_i),
    .data_be_i     (data_be_i),
    .data_addr_i   (data_addr_i),
    .data_wdata_i  (data_wdata_i),
    .data_rvalid_o (data_rvalid_o),
    .data_rdata_o  (data_rdata_o),
    .data_err_o    (data_err_o),
    .axi           (axi_bus)
  );

  int checks = 0;
  int errors = 0;

  txn_t        cfg[$];
  logic [31:0] model_mem [16];
  int          exp_pulses = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic txn_t mk(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [3:0] be, input int aw, input int w, input int b,
                              input int ar, input int r, input logic [1:0] resp,
                              input logic err, input logic [31:0] rdata, input int lat);
    txn_t t;
    t.we = we; t.addr = addr; t.wdata = wdata; t.be = be;
    t.aw_stall = aw; t.w_stall = w; t.b_delay = b; t.ar_stall = ar; t.r_delay = r;
    t.resp = resp; t.exp_err = err; t.exp_rdata = rdata; t.exp_lat = lat; t.exp_word = '0;
    return t;
  endfunction

  // Reference model: word memory with byte-enable merge; expected response
  // and latency from the channel stall counts.
  task automatic push_txn(input txn_t t_in, input bit auto_exp);
    txn_t t = t_in;
    int   idx = int'(t.addr[5:2]);
    if (auto_exp) begin
      t.exp_err   = t.resp[1];
      t.exp_rdata = t.we ? 32'h0 : model_mem[idx];
      t.exp_lat   = t.we ? 3 + ((t.aw_stall > t.w_stall) ? t.aw_stall : t.w_stall) + t.b_delay
                         : 3 + t.ar_stall + t.r_delay;
    end
    if (t.we) begin
      for (int b = 0; b < 4; b++)
        if (t.be[b]) model_mem[idx][8*b +: 8] = t.wdata[8*b +: 8];
    end
    t.exp_word = model_mem[idx];
    cfg.push_back(t);
  endtask

  // ---------------- slave model ----------------
  logic [31:0] s_mem [16];
  int          s_t = 0;
  int          aw_used, w_used, ar_used, b_wait, r_wait;
  bit          got_aw, got_w, b_pend, r_pend;
  bit          hs_aw, hs_w, hs_b, hs_ar, hs_r;
  logic [31:0] cap_awaddr, cap_wdata, cap_araddr;
  logic [3:0]  cap_wstrb;
  logic [31:0] s_awaddr, s_wdata, s_araddr;
  logic [3:0]  s_wstrb;
  logic [31:0] s_last_awaddr, s_last_araddr;
  txn_t        s_c;

  task automatic slave_clear();
    got_aw = 0; got_w = 0; b_pend = 0; r_pend = 0;
    hs_aw = 0; hs_w = 0; hs_b = 0; hs_ar = 0; hs_r = 0;
    aw_used = 0; w_used = 0; ar_used = 0; b_wait = 0; r_wait = 0;
    axi_bus.bvalid = 0; axi_bus.rvalid = 0;
    axi_bus.awready = 0; axi_bus.wready = 0; axi_bus.arready = 0;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) s_mem[i] = '0;
    axi_bus.bresp = OKAY; axi_bus.rresp = OKAY; axi_bus.rdata = '0;
    s_last_awaddr = '0; s_last_araddr = '0;
    slave_clear();
    forever begin
      @(negedge aclk);
      if (areset) begin
        // an abandoned transaction consumes its configuration slot
        if (got_aw || got_w || b_pend || r_pend || axi_bus.bvalid || axi_bus.rvalid ||
            hs_aw || hs_w || hs_ar)
          s_t++;
        slave_clear();
      end else begin
        if (hs_aw) begin got_aw = 1; s_awaddr = cap_awaddr; end
        if (hs_w)  begin got_w = 1; s_wdata = cap_wdata; s_wstrb = cap_wstrb; end
        if (hs_ar) begin r_pend = 1; r_wait = 0; s_araddr = cap_araddr; s_last_araddr = cap_araddr; end
        if (hs_b || hs_r) begin
          axi_bus.bvalid = 0; axi_bus.rvalid = 0;
          s_t++;
          aw_used = 0; w_used = 0; ar_used = 0;
        end
        if (got_aw && got_w) begin
          for (int b = 0; b < 4; b++)
            if (s_wstrb[b]) s_mem[s_awaddr[5:2]][8*b +: 8] = s_wdata[8*b +: 8];
          s_last_awaddr = s_awaddr;
          got_aw = 0; got_w = 0; b_pend = 1; b_wait = 0;
        end
        if (s_t < cfg.size()) s_c = cfg[s_t];
        else s_c = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, OKAY, 0, 0, 0);
        if (b_pend) begin
          if (b_wait >= s_c.b_delay) begin
            axi_bus.bvalid = 1; axi_bus.bresp = s_c.resp; b_pend = 0;
          end else b_wait++;
        end
        if (r_pend) begin
          if (r_wait >= s_c.r_delay) begin
            axi_bus.rvalid = 1; axi_bus.rresp = s_c.resp;
            axi_bus.rdata = s_mem[s_araddr[5:2]]; r_pend = 0;
          end else r_wait++;
        end
        axi_bus.awready = (aw_used >= s_c.aw_stall);
        if (axi_bus.awvalid && !axi_bus.awready) aw_used++;
        axi_bus.wready = (w_used >= s_c.w_stall);
        if (axi_bus.wvalid && !axi_bus.wready) w_used++;
        axi_bus.arready = (ar_used >= s_c.ar_stall);
        if (axi_bus.arvalid && !axi_bus.arready) ar_used++;
        hs_aw = axi_bus.awvalid && axi_bus.awready;
        hs_w  = axi_bus.wvalid && axi_bus.wready;
        hs_ar = axi_bus.arvalid && axi_bus.arready;
        hs_b  = axi_bus.bvalid && axi_bus.bready;
        hs_r  = axi_bus.rvalid && axi_bus.rready;
        cap_awaddr = axi_bus.awaddr;
        cap_wdata = axi_bus.wdata; cap_wstrb = axi_bus.wstrb;
        cap_araddr = axi_bus.araddr;
      end
    end
  end

  // ---------------- protocol monitor ----------------
  int          av_cyc = 0, wv_cyc = 0, rv_pulses = 0;
  logic        p_rst = 1'b1;
  logic        p_awv = 0, p_awr = 0, p_wv = 0, p_wr = 0, p_arv = 0, p_arr = 0;
  logic [31:0] p_awaddr, p_wdata, p_araddr;
  logic [3:0]  p_wstrb;

  initial begin
    forever begin
      @(negedge aclk);
      if (!p_rst) begin
        if (p_awv && !p_awr) begin
          chk("aw_hold_valid", {31'b0, axi_bus.awvalid}, 32'h1);
          chk("aw_hold_addr", axi_bus.awaddr, p_awaddr);
        end
        if (p_wv && !p_wr) begin
          chk("w_hold_valid", {31'b0, axi_bus.wvalid}, 32'h1);
          chk("w_hold_data", axi_bus.wdata, p_wdata);
          chk("w_hold_strb", {28'b0, axi_bus.wstrb}, {28'b0, p_wstrb});
        end
        if (p_arv && !p_arr) begin
          chk("ar_hold_valid", {31'b0, axi_bus.arvalid}, 32'h1);
          chk("ar_hold_addr", axi_bus.araddr, p_araddr);
        end
      end
      if (data_gnt_o)
        chk("no_valid_in_gnt_cycle",
            {29'b0, axi_bus.awvalid, axi_bus.wvalid, axi_bus.arvalid}, 32'h0);
      if (axi_bus.awvalid) av_cyc++;
      if (axi_bus.wvalid) wv_cyc++;
      if (data_rvalid_o) rv_pulses++;
      p_rst = areset;
      p_awv = axi_bus.awvalid; p_awr = axi_bus.awready; p_awaddr = axi_bus.awaddr;
      p_wv = axi_bus.wvalid; p_wr = axi_bus.wready; p_wdata = axi_bus.wdata; p_wstrb = axi_bus.wstrb;
      p_arv = axi_bus.arvalid; p_arr = axi_bus.arready; p_araddr = axi_bus.araddr;
    end
  end

  // ---------------- driver ----------------
  task automatic present(input int k);
    data_req_i = 1; data_we_i = cfg[k].we; data_addr_i = cfg[k].addr;
    data_wdata_i = cfg[k].wdata; data_be_i = cfg[k].be;
  endtask

  // Runs cfg[first .. first+n-1]. Called and returns just after a rising edge.
  task automatic run_batch(input int first, input int n, input bit hold);
    int nxt = first, pend = -1, gcyc = 0, cyc = 0, done = 0, prev_lat = 0;
    present(nxt);
    while (done < n && cyc < 60 * n) begin
      @(negedge aclk);
      if (data_rvalid_o) begin
        if (pend < 0) chk("spurious_rvalid", 32'h1, 32'h0);
        else begin
          chk("rsp_rdata", data_rdata_o, cfg[pend].exp_rdata);
          chk("rsp_err", {31'b0, data_err_o}, {31'b0, cfg[pend].exp_err});
          chk("rsp_latency", cyc - gcyc, cfg[pend].exp_lat);
          if (cfg[pend].we) begin
            chk("slave_awaddr", s_last_awaddr, cfg[pend].addr);
            chk("slave_word", s_mem[cfg[pend].addr[5:2]], cfg[pend].exp_word);
          end else
            chk("slave_araddr", s_last_araddr, cfg[pend].addr);
          done++; exp_pulses++; pend = -1;
        end
      end
      if (data_gnt_o) begin
        if (hold && nxt > first) begin
          chk("b2b_gnt_gap", cyc - gcyc, prev_lat);
          chk("b2b_gnt_with_rvalid", {31'b0, data_rvalid_o}, 32'h1);
        end
        pend = nxt; gcyc = cyc; prev_lat = cfg[nxt].exp_lat; nxt++;
      end
      @(posedge aclk); #1; cyc++;
      if (nxt < first + n && (hold || pend < 0)) present(nxt);
      else data_req_i = 0;
    end
    data_req_i = 0;
    if (done < n) chk("batch_timeout", done, n);
  endtask

  txn_t vec [11];

  initial begin
    int   base, rbase;
    txn_t t;
    for (int i = 0; i < 16; i++) model_mem[i] = '0;

    vec[0]  = mk(1, 32'h00, 32'h0000_000A, 4'hF, 0, 0, 0, 0, 0, OKAY,   0, 32'h0,         3);
    vec[1]  = mk(0, 32'h00, 32'h0,         4'hF, 0, 0, 0, 0, 0, OKAY,   0, 32'h0000_000A, 3);
    vec[2]  = mk(1, 32'h04, 32'h1234_5678, 4'h5, 0, 0, 0, 0, 0, OKAY,   0, 32'h0,         3);
    vec[3]  = mk(0, 32'h04, 32'h0,         4'hF, 0, 0, 0, 0, 0, OKAY,   0, 32'h0034_0078, 3);
    vec[4]  = mk(1, 32'h08, 32'hDEAD_BEEF, 4'h0, 0, 0, 0, 0, 0, OKAY,   0, 32'h0,         3);
    vec[5]  = mk(0, 32'h08, 32'h0,         4'hF, 0, 0, 0, 0, 0, OKAY,   0, 32'h0,         3);
    vec[6]  = mk(1, 32'h0C, 32'h0000_0055, 4'hF, 0, 0, 0, 0, 0, SLVERR, 1, 32'h0,         3);
    vec[7]  = mk(0, 32'h0C, 32'h0,         4'hF, 0, 0, 0, 0, 0, DECERR, 1, 32'h0000_0055, 3);
    vec[8]  = mk(0, 32'h00, 32'h0,         4'hF, 0, 0, 0, 0, 0, EXOKAY, 0, 32'h0000_000A, 3);
    vec[9]  = mk(1, 32'h10, 32'h0000_0077, 4'hF, 0, 2, 1, 0, 0, OKAY,   0, 32'h0,         6);
    vec[10] = mk(0, 32'h10, 32'h0,         4'hF, 0, 0, 0, 2, 3, OKAY,   0, 32'h0000_0077, 8);

    // reset, with a request pending that must not be granted
    areset = 1; data_req_i = 1; data_we_i = 0; data_be_i = 4'hF;
    data_addr_i = '0; data_wdata_i = '0;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    chk("rst_gnt", {31'b0, data_gnt_o}, 32'h0);
    chk("rst_rvalid", {31'b0, data_rvalid_o}, 32'h0);
    chk("rst_rdata", data_rdata_o, 32'h0);
    chk("rst_err", {31'b0, data_err_o}, 32'h0);
    chk("rst_axi_valids", {27'b0, axi_bus.awvalid, axi_bus.wvalid, axi_bus.arvalid,
                           axi_bus.bready, axi_bus.rready}, 32'h0);
    @(posedge aclk); #1;
    areset = 0; data_req_i = 0;
    @(posedge aclk); #1;

    // directed table
    for (int i = 0; i < 11; i++) begin
      push_txn(vec[i], 0);
      run_batch(cfg.size() - 1, 1, 0);
    end
    chk("led_readback", s_mem[0], 32'h0000_000A);

    // split AW/W: AW stalled 3 cycles while W is accepted immediately
    av_cyc = 0; wv_cyc = 0;
    push_txn(mk(1, 32'h14, 32'h0000_0099, 4'hF, 3, 0, 0, 0, 0, OKAY, 0, 0, 0), 1);
    run_batch(cfg.size() - 1, 1, 0);
    chk("split_wvalid_cycles", wv_cyc, 1);
    chk("split_awvalid_cycles", av_cyc, 4);

    // back-to-back write, read, write with req held
    base = cfg.size();
    push_txn(mk(1, 32'h18, 32'h1111_1111, 4'hF, 0, 0, 0, 0, 0, OKAY, 0, 0, 0), 1);
    push_txn(mk(0, 32'h00, 32'h0,         4'hF, 0, 0, 0, 0, 0, OKAY, 0, 0, 0), 1);
    push_txn(mk(1, 32'h1C, 32'h2222_2222, 4'hF, 0, 0, 0, 0, 0, OKAY, 0, 0, 0), 1);
    run_batch(base, 3, 1);

    // reset while in WB with bvalid low
    push_txn(mk(1, 32'h3C, 32'hCAFE_F00D, 4'hF, 0, 0, 50, 0, 0, OKAY, 0, 0, 0), 1);
    present(cfg.size() - 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge aclk);
      if (data_gnt_o) break;
      @(posedge aclk); #1;
    end
    chk("rstmid_granted", {31'b0, data_gnt_o}, 32'h1);
    @(posedge aclk); #1; data_req_i = 0;
    @(posedge aclk); #1;
    @(negedge aclk);
    chk("rstmid_in_wb", {30'b0, axi_bus.bready, axi_bus.bvalid}, 32'h2);
    @(posedge aclk); #1; areset = 1;
    @(posedge aclk); #1; areset = 0;
    @(negedge aclk);
    chk("rstmid_axi_idle", {27'b0, axi_bus.awvalid, axi_bus.wvalid, axi_bus.arvalid,
                            axi_bus.bready, axi_bus.rready}, 32'h0);
    chk("rstmid_no_rvalid", {31'b0, data_rvalid_o}, 32'h0);
    chk("rstmid_rdata", data_rdata_o, 32'h0);
    repeat (3) @(posedge aclk);
    #1;
    push_txn(mk(0, 32'h00, 32'h0, 4'hF, 0, 0, 0, 0, 0, OKAY, 0, 0, 0), 1);
    run_batch(cfg.size() - 1, 1, 0);

    // random traffic, idle-separated and then back-to-back
    rbase = cfg.size();
    for (int i = 0; i < 50; i++) begin
      t = mk($urandom_range(0, 1), {26'b0, 4'($urandom_range(0, 15)), 2'b00}, $urandom,
             4'($urandom_range(0, 15)), $urandom_range(0, 3), $urandom_range(0, 3),
             $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
             2'($urandom_range(0, 3)), 0, 0, 0);
      push_txn(t, 1);
    end
    run_batch(rbase, 30, 0);
    run_batch(rbase + 30, 20, 1);

    repeat (3) @(posedge aclk);
    #1;
    chk("rvalid_pulse_count", rv_pulses, exp_pulses);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
